id_queue_decode: RTL

- Next-generation RV32I decode stage. Places a parametrised instruction queue between IF and decode, plus a registered decode output with valid/ready handshakes.
- Decodes the queue head and resolves operands from the regfile, EX forwarding and MEM forwarding.
- Detects load-use hazards and hazards against its own output register, and holds the head while either is present.
- Supports flush on branch mispredict and counts hazard stall cycles.

---
 rtl/riscv_id_pkg.sv | 87 ++++++++
 rtl/id_queue_decode_if.sv | 11 +
 rtl/id_decode_comb.sv | 145 ++++++++++++++
 rtl/id_queue_decode.sv | 231 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_id_pkg.sv
// Shared RV32I decode definitions: opcodes, funct fields, ALU encodings,
// immediate formats and the decoded-instruction record.
package riscv_id_pkg;

    // Major opcodes
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_OP     = 7'b0110011;

    // funct3 for OP / OP-IMM
    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;
    localparam logic [2:0] F3_AND  = 3'b111;

    // funct3 for branches
    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    // funct3 for loads / stores
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // funct7
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam int AOP_W = 6;
    localparam int SEL_W = 3;

    typedef enum logic [AOP_W-1:0] {
        AOP_NOP, AOP_ADD, AOP_SUB, AOP_SLL, AOP_SLT, AOP_SLTU, AOP_XOR,
        AOP_SRL, AOP_SRA, AOP_OR, AOP_AND, AOP_LUI, AOP_AUIPC, AOP_JAL,
        AOP_JALR, AOP_BEQ, AOP_BNE, AOP_BLT, AOP_BGE, AOP_BLTU, AOP_BGEU,
        AOP_LB, AOP_LH, AOP_LW, AOP_LBU, AOP_LHU, AOP_SB, AOP_SH, AOP_SW
    } aluop_e;

    typedef enum logic [SEL_W-1:0] {
        SEL_NOP, SEL_LOGIC, SEL_SHIFT, SEL_ARITH,
        SEL_JUMP, SEL_BRANCH, SEL_LOAD, SEL_STORE
    } alusel_e;

    typedef enum logic [2:0] {
        IMM_NONE, IMM_I, IMM_SH, IMM_S, IMM_B, IMM_U, IMM_J
    } imm_fmt_e;

    typedef struct packed {
        aluop_e      aluop;
        alusel_e     alusel;
        logic [31:0] imm;
        logic        re1;
        logic        re2;
        logic        wreg;
        logic        illegal;
    } dec_t;

    // Assemble the 32-bit immediate of the given format.
    function automatic logic [31:0] gen_imm(input logic [31:0] inst, input imm_fmt_e fmt);
        case (fmt)
            IMM_I:   return {{20{inst[31]}}, inst[31:20]};
            IMM_SH:  return {27'b0, inst[24:20]};
            IMM_S:   return {{20{inst[31]}}, inst[31:25], inst[11:7]};
            IMM_B:   return {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
            IMM_U:   return {inst[31:12], 12'b0};
            IMM_J:   return {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
            default: return 32'b0;
        endcase
    endfunction

endpackage

// File: rtl/id_queue_decode_if.sv
// Fetch-to-queue handshake: IF is the master, the decode queue the slave.
interface id_queue_decode_if #(parameter int XLEN = 32);
    logic            if_valid;
    logic [XLEN-1:0] if_pc;
    logic [31:0]     if_inst;
    logic            if_jmp;
    logic            if_ready;

    modport master (output if_valid, if_pc, if_inst, if_jmp, input if_ready);
    modport slave  (input if_valid, if_pc, if_inst, if_jmp, output if_ready);
endinterface

// File: rtl/id_decode_comb.sv
// Pure combinational RV32I decode of one instruction word.
module id_decode_comb
    import riscv_id_pkg::*;
(
    input  logic [31:0] i_inst,
    output dec_t        o_dec
);

    logic [6:0] w_opcode;
    logic [2:0] w_f3;
    logic [6:0] w_f7;

    aluop_e   w_aluop;
    alusel_e  w_sel;
    imm_fmt_e w_fmt;
    logic     w_re1;
    logic     w_re2;
    logic     w_wreg;
    logic     w_ill;

    assign w_opcode = i_inst[6:0];
    assign w_f3     = i_inst[14:12];
    assign w_f7     = i_inst[31:25];

    // Classify the opcode/funct fields; unknown encodings collapse to a NOP.
    always_comb begin
        // NOTE: every signal gets a default before the case so no path can leave it unassigned and infer a latch.
        w_aluop = AOP_NOP;
        w_sel   = SEL_NOP;
        w_fmt   = IMM_NONE;
        w_re1   = 1'b0;
        w_re2   = 1'b0;
        w_wreg  = 1'b0;
        w_ill   = 1'b0;
        case (w_opcode)
            OP_LUI: begin
                w_aluop = AOP_LUI; w_sel = SEL_ARITH; w_fmt = IMM_U; w_wreg = 1'b1;
            end
            OP_AUIPC: begin
                w_aluop = AOP_AUIPC; w_sel = SEL_ARITH; w_fmt = IMM_U; w_wreg = 1'b1;
            end
            OP_JAL: begin
                w_aluop = AOP_JAL; w_sel = SEL_JUMP; w_fmt = IMM_J; w_wreg = 1'b1;
            end
            OP_JALR: begin
                w_aluop = AOP_JALR; w_sel = SEL_JUMP; w_fmt = IMM_I; w_re1 = 1'b1; w_wreg = 1'b1;
                w_ill   = (w_f3 != 3'b000);
            end
            OP_BRANCH: begin
                w_sel = SEL_BRANCH; w_fmt = IMM_B; w_re1 = 1'b1; w_re2 = 1'b1;
                case (w_f3)
                    F3_BEQ:  w_aluop = AOP_BEQ;
                    F3_BNE:  w_aluop = AOP_BNE;
                    F3_BLT:  w_aluop = AOP_BLT;
                    F3_BGE:  w_aluop = AOP_BGE;
                    F3_BLTU: w_aluop = AOP_BLTU;
                    F3_BGEU: w_aluop = AOP_BGEU;
                    default: w_ill   = 1'b1;
                endcase
            end
            OP_LOAD: begin
                w_sel = SEL_LOAD; w_fmt = IMM_I; w_re1 = 1'b1; w_wreg = 1'b1;
                case (w_f3)
                    F3_LB:   w_aluop = AOP_LB;
                    F3_LH:   w_aluop = AOP_LH;
                    F3_LW:   w_aluop = AOP_LW;
                    F3_LBU:  w_aluop = AOP_LBU;
                    F3_LHU:  w_aluop = AOP_LHU;
                    default: w_ill   = 1'b1;
                endcase
            end
            OP_STORE: begin
                w_sel = SEL_STORE; w_fmt = IMM_S; w_re1 = 1'b1; w_re2 = 1'b1;
                case (w_f3)
                    3'b000:  w_aluop = AOP_SB;
                    3'b001:  w_aluop = AOP_SH;
                    3'b010:  w_aluop = AOP_SW;
                    default: w_ill   = 1'b1;
                endcase
            end
            OP_IMM: begin
                w_fmt = IMM_I; w_re1 = 1'b1; w_wreg = 1'b1; w_sel = SEL_ARITH;
                case (w_f3)
                    F3_ADD:  w_aluop = AOP_ADD;
                    F3_SLT:  w_aluop = AOP_SLT;
                    F3_SLTU: w_aluop = AOP_SLTU;
                    F3_XOR:  begin w_aluop = AOP_XOR; w_sel = SEL_LOGIC; end
                    F3_OR:   begin w_aluop = AOP_OR;  w_sel = SEL_LOGIC; end
                    F3_AND:  begin w_aluop = AOP_AND; w_sel = SEL_LOGIC; end
                    F3_SLL: begin
                        w_aluop = AOP_SLL; w_sel = SEL_SHIFT; w_fmt = IMM_SH;
                        w_ill   = (w_f7 != F7_BASE);
                    end
                    default: begin // F3_SR
                        w_sel = SEL_SHIFT; w_fmt = IMM_SH;
                        if (w_f7 == F7_BASE)     w_aluop = AOP_SRL;
                        else if (w_f7 == F7_ALT) w_aluop = AOP_SRA;
                        else                     w_ill   = 1'b1;
                    end
                endcase
            end
            OP_OP: begin
                w_re1 = 1'b1; w_re2 = 1'b1; w_wreg = 1'b1; w_sel = SEL_ARITH;
                if (w_f7 == F7_BASE) begin
                    case (w_f3)
                        F3_ADD:  w_aluop = AOP_ADD;
                        F3_SLT:  w_aluop = AOP_SLT;
                        F3_SLTU: w_aluop = AOP_SLTU;
                        F3_XOR:  begin w_aluop = AOP_XOR; w_sel = SEL_LOGIC; end
                        F3_OR:   begin w_aluop = AOP_OR;  w_sel = SEL_LOGIC; end
                        F3_AND:  begin w_aluop = AOP_AND; w_sel = SEL_LOGIC; end
                        F3_SLL:  begin w_aluop = AOP_SLL; w_sel = SEL_SHIFT; end
                        default: begin w_aluop = AOP_SRL; w_sel = SEL_SHIFT; end
                    endcase
                end else if (w_f7 == F7_ALT && w_f3 == F3_ADD) begin
                    w_aluop = AOP_SUB;
                end else if (w_f7 == F7_ALT && w_f3 == F3_SR) begin
                    w_aluop = AOP_SRA; w_sel = SEL_SHIFT;
                end else begin
                    w_ill = 1'b1;
                end
            end
            default: w_ill = 1'b1;
        endcase

        // An illegal encoding must not read or write registers.
        if (w_ill) begin
            w_aluop = AOP_NOP;
            w_sel   = SEL_NOP;
            w_fmt   = IMM_NONE;
            w_re1   = 1'b0;
            w_re2   = 1'b0;
            w_wreg  = 1'b0;
        end
    end

    assign o_dec = '{aluop:   w_aluop,
                     alusel:  w_sel,
                     imm:     gen_imm(i_inst, w_fmt),
                     re1:     w_re1,
                     re2:     w_re2,
                     wreg:    w_wreg,
                     illegal: w_ill};

endmodule

// File: rtl/id_queue_decode.sv
// Decode stage: instruction queue from IF, head decode with operand
// forwarding, hazard hold, and a registered valid/ready output to EX.
module id_queue_decode
    import riscv_id_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int DEPTH  = 4,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 32
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             rdy,
    input  logic             flush,
    id_queue_decode_if.slave fetch,
    output logic [4:0]       rs1_addr_o,
    output logic [4:0]       rs2_addr_o,
    input  logic [XLEN-1:0]  rs1_data_i,
    input  logic [XLEN-1:0]  rs2_data_i,
    input  logic             ex_wreg_i,
    input  logic             ex_loading_i,
    input  logic [4:0]       ex_wd_i,
    input  logic [XLEN-1:0]  ex_wdata_i,
    input  logic             mem_wreg_i,
    input  logic [4:0]       mem_wd_i,
    input  logic [XLEN-1:0]  mem_wdata_i,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [AOP_W-1:0] aluop_o,
    output logic [SEL_W-1:0] alusel_o,
    output logic [XLEN-1:0]  reg1_o,
    output logic [XLEN-1:0]  reg2_o,
    output logic [XLEN-1:0]  offset_o,
    output logic [4:0]       wd_o,
    output logic             wreg_o,
    output logic [XLEN-1:0]  pc_o,
    output logic             jmp_o,
    output logic             illegal_o,
    output logic             hazard_stall_o,
    output logic [CNT_W-1:0] hazard_cnt_o
);

    localparam int            PW      = $clog2(DEPTH);
    localparam logic [PW:0]   PTR_ONE = 1;
    localparam logic [CNT_W-1:0] CNT_ONE = 1;

    // Queue storage and pointers (extra MSB distinguishes full from empty)
    logic [XLEN-1:0] r_q_pc   [DEPTH];
    logic [31:0]     r_q_inst [DEPTH];
    logic            r_q_jmp  [DEPTH];
    logic [PW:0]     r_wptr;
    logic [PW:0]     r_rptr;

    // Output register
    logic            r_out_valid;
    aluop_e          r_aluop;
    alusel_e         r_alusel;
    logic [XLEN-1:0] r_reg1;
    logic [XLEN-1:0] r_reg2;
    logic [XLEN-1:0] r_offset;
    logic [4:0]      r_wd;
    logic            r_wreg;
    logic [XLEN-1:0] r_pc;
    logic            r_jmp;
    logic            r_illegal;
    logic [CNT_W-1:0] r_hazard_cnt;

    logic            w_full;
    logic            w_empty;
    logic            w_push;
    logic            w_pop;
    logic [31:0]     w_head_inst;
    logic [XLEN-1:0] w_head_pc;
    logic            w_head_jmp;
    dec_t            w_dec;
    logic [4:0]      w_rs1;
    logic [4:0]      w_rs2;
    logic [4:0]      w_rd;
    logic [XLEN-1:0] w_imm;
    logic            w_ex_hit;
    logic            w_mem_hit;
    logic            w_h_out;
    logic            w_h_load;
    logic            w_h_nofwd;
    logic            w_hazard;
    logic [XLEN-1:0] w_op1;
    logic [XLEN-1:0] w_op2;

    // x0 reads zero, then the youngest producer (EX) wins over MEM and the regfile.
    function automatic logic [XLEN-1:0] resolve(
        input logic [4:0]      rs,
        input logic [XLEN-1:0] rf,
        input logic            exw,
        input logic [4:0]      exd,
        input logic [XLEN-1:0] exv,
        input logic            memw,
        input logic [4:0]      memd,
        input logic [XLEN-1:0] memv
    );
        if (rs == 5'd0)                return '0;
        else if (exw && exd == rs)     return exv;
        else if (memw && memd == rs)   return memv;
        else                           return rf;
    endfunction

    assign w_empty = (r_wptr == r_rptr);
    assign w_full  = (r_wptr[PW] != r_rptr[PW]) && (r_wptr[PW-1:0] == r_rptr[PW-1:0]);

    assign fetch.if_ready = !w_full;

    assign w_head_inst = r_q_inst[r_rptr[PW-1:0]];
    assign w_head_pc   = r_q_pc[r_rptr[PW-1:0]];
    assign w_head_jmp  = r_q_jmp[r_rptr[PW-1:0]];

    id_decode_comb u_dec (
        .i_inst (w_head_inst),
        .o_dec  (w_dec)
    );

    assign w_rs1      = w_head_inst[19:15];
    assign w_rs2      = w_head_inst[24:20];
    assign w_rd       = w_head_inst[11:7];
    assign rs1_addr_o = w_rs1;
    assign rs2_addr_o = w_rs2;
    assign w_imm      = XLEN'($signed(w_dec.imm));

    assign w_ex_hit  = (w_dec.re1 && w_rs1 == ex_wd_i)  || (w_dec.re2 && w_rs2 == ex_wd_i);
    assign w_mem_hit = (w_dec.re1 && w_rs1 == mem_wd_i) || (w_dec.re2 && w_rs2 == mem_wd_i);

    assign w_h_out   = r_out_valid && r_wreg && (r_wd != 5'd0) &&
                       ((w_dec.re1 && w_rs1 == r_wd) || (w_dec.re2 && w_rs2 == r_wd));
    assign w_h_load  = ex_loading_i && (ex_wd_i != 5'd0) && w_ex_hit;
    assign w_h_nofwd = (FWD_EN == 0) &&
                       ((ex_wreg_i  && (ex_wd_i  != 5'd0) && w_ex_hit) ||
                        (mem_wreg_i && (mem_wd_i != 5'd0) && w_mem_hit));

    assign w_hazard = !flush && !w_empty && (w_h_out || w_h_load || w_h_nofwd);
    assign w_push   = !flush && fetch.if_valid && !w_full;
    assign w_pop    = !flush && !w_empty && !w_hazard && (!r_out_valid || out_ready);

    assign w_op1 = resolve(w_rs1, rs1_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                           mem_wreg_i, mem_wd_i, mem_wdata_i);
    assign w_op2 = resolve(w_rs2, rs2_data_i, ex_wreg_i, ex_wd_i, ex_wdata_i,
                           mem_wreg_i, mem_wd_i, mem_wdata_i);

    // Write accepted fetch beats into the circular buffer.
    always_ff @(posedge clk) begin
        // NOTE: queue storage has no reset; the pointers alone define which entries are live.
        if (rdy && w_push) begin
            r_q_pc[r_wptr[PW-1:0]]   <= fetch.if_pc;
            r_q_inst[r_wptr[PW-1:0]] <= fetch.if_inst;
            r_q_jmp[r_wptr[PW-1:0]]  <= fetch.if_jmp;
        end
    end

    // Advance read/write pointers; flush empties the queue.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
        if (rst) begin
            r_wptr <= '0;
            r_rptr <= '0;
        end else if (rdy) begin
            if (flush) begin
                r_wptr <= '0;
                r_rptr <= '0;
            end else begin
                if (w_push) r_wptr <= r_wptr + PTR_ONE;
                if (w_pop)  r_rptr <= r_rptr + PTR_ONE;
            end
        end
    end

    // Capture the decoded head on pop, drop valid once EX has taken it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_aluop     <= AOP_NOP;
            r_alusel    <= SEL_NOP;
            r_reg1      <= '0;
            r_reg2      <= '0;
            r_offset    <= '0;
            r_wd        <= '0;
            r_wreg      <= 1'b0;
            r_pc        <= '0;
            r_jmp       <= 1'b0;
            r_illegal   <= 1'b0;
        end else if (rdy) begin
            if (flush) begin
                r_out_valid <= 1'b0;
            end else if (w_pop) begin
                r_out_valid <= 1'b1;
                r_aluop     <= w_dec.aluop;
                r_alusel    <= w_dec.alusel;
                r_reg1      <= w_dec.re1 ? w_op1 : w_imm;
                r_reg2      <= w_dec.re2 ? w_op2 : w_imm;
                r_offset    <= w_imm;
                r_wd        <= w_rd;
                r_wreg      <= w_dec.wreg;
                r_pc        <= w_head_pc;
                r_jmp       <= w_head_jmp;
                r_illegal   <= w_dec.illegal;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

    // Count hazard stall cycles; survives flush and wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hazard_cnt <= '0;
        end else if (rdy && w_hazard) begin
            r_hazard_cnt <= r_hazard_cnt + CNT_ONE;
        end
    end

    assign out_valid      = r_out_valid;
    assign aluop_o        = r_aluop;
    assign alusel_o       = r_alusel;
    assign reg1_o         = r_reg1;
    assign reg2_o         = r_reg2;
    assign offset_o       = r_offset;
    assign wd_o           = r_wd;
    assign wreg_o         = r_wreg;
    assign pc_o           = r_pc;
    assign jmp_o          = r_jmp;
    assign illegal_o      = r_illegal;
    assign hazard_stall_o = w_hazard;
    assign hazard_cnt_o   = r_hazard_cnt;

endmodule
